snake_step_scheduler: RTL and testbench

//  Paces the snake datapath. Sits beside game_state and consumes its init_snake/screen_black/screen_pause.

---
 rtl/snake_step_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_snake_step_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/snake_step_scheduler.sv
// Step pacing and turn queueing for the snake datapath: one-cycle step strobes, 2-deep arrow-key buffer.
// Build option: define SNAKE_SPEEDUP_EN to shrink the step period as the snake grows.
module snake_step_scheduler #(
    parameter int          CNT_W           = 24,
    parameter int unsigned BASE_PERIOD     = 5_000_000,
    parameter int unsigned PERIOD_DEC      = 400_000,
    parameter int unsigned MIN_PERIOD      = 1_000_000,
    parameter int unsigned GROWS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL       = 10,
    parameter int unsigned START_DELAY     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_snake,
    input  logic       screen_black,
    input  logic       screen_pause,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       grow,
    output logic       step,
    output logic [1:0] dir,
    output logic [3:0] speed_level,
    output logic       running
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

    localparam logic [1:0]       DIR_UP    = 2'd0;
    localparam logic [1:0]       DIR_RIGHT = 2'd1;
    localparam logic [1:0]       DIR_DOWN  = 2'd2;
    localparam logic [1:0]       DIR_LEFT  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] period_new;
    logic             step_q, step_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       q0_q, q0_d, q1_q, q1_d;
    logic [1:0]       q_cnt_q, q_cnt_d;

    logic       init_go, ok_state, run_go, wrap, key_en;
    logic       key_hit, push, pop;
    logic [1:0] key_dir, tail_dir, ref_dir;

    // screen_black outranks init_snake, which outranks everything state-specific.
    assign init_go  = init_snake && !screen_black;
    assign ok_state = !screen_black && !init_snake;
    assign run_go   = ok_state && (state_q == RUN || state_q == HOLD) && !screen_pause;
    assign wrap     = run_go && (cnt_q == period_q - CNT_ONE);
    assign key_en   = ok_state && (state_q == ARM || run_go);

    always_comb begin
        key_hit = 1'b1;
        key_dir = DIR_UP;
        case (key_code)
            8'h75:   key_dir = DIR_UP;
            8'h74:   key_dir = DIR_RIGHT;
            8'h72:   key_dir = DIR_DOWN;
            8'h6B:   key_dir = DIR_LEFT;
            default: key_hit = 1'b0;
        endcase
    end

    assign tail_dir = (q_cnt_q == 2'd2) ? q1_q : q0_q;
    assign ref_dir  = (q_cnt_q != 2'd0) ? tail_dir : dir_q;
    assign pop      = wrap && (q_cnt_q != 2'd0);
    assign push     = key_en && key_valid && key_hit
                   && (key_dir != ref_dir) && (key_dir != (ref_dir ^ 2'd2))
                   && (q_cnt_q != 2'd2 || pop);

`ifdef SNAKE_SPEEDUP_EN
    localparam int GROW_W = $clog2(GROWS_PER_LEVEL + 1);
    localparam int DEC_W  = CNT_W + 4;

    logic [3:0]        level_q, level_d;
    logic [GROW_W-1:0] grow_cnt_q, grow_cnt_d;
    logic [DEC_W-1:0]  dec, diff;

    always_comb begin
        level_d    = level_q;
        grow_cnt_d = grow_cnt_q;
        if (init_go) begin
            level_d    = 4'd0;
            grow_cnt_d = '0;
        end else if (run_go && grow) begin
            if (grow_cnt_q == GROW_W'(GROWS_PER_LEVEL - 1)) begin
                grow_cnt_d = '0;
                if (level_q != 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
            end else begin
                grow_cnt_d = grow_cnt_q + GROW_W'(1);
            end
        end
    end

    // Subtract only when the result stays above the floor, so the period can never underflow.
    always_comb begin
        dec  = DEC_W'(level_q) * DEC_W'(PERIOD_DEC);
        diff = DEC_W'(BASE_PERIOD) - dec;
        if (DEC_W'(BASE_PERIOD) > dec && diff > DEC_W'(MIN_PERIOD))
            period_new = CNT_W'(diff);
        else
            period_new = CNT_W'(MIN_PERIOD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= 4'd0;
            grow_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            grow_cnt_q <= grow_cnt_d;
        end
    end

    assign speed_level = level_q;
`else
    logic unused_grow;
    assign unused_grow = grow;
    assign period_new  = CNT_W'(BASE_PERIOD);
    assign speed_level = 4'd0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        q_cnt_d  = q_cnt_q;

        if (screen_black) begin
            state_d = IDLE;
            cnt_d   = '0;
            q_cnt_d = 2'd0;
        end else if (init_snake) begin
            state_d = ARM;
            cnt_d   = '0;
            dir_d   = DIR_RIGHT;
            q_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ARM: begin
                    if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        period_d = period_new;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN, HOLD: begin
                    if (screen_pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (wrap) begin
                            cnt_d    = '0;
                            period_d = period_new;
                            step_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase

            // The head moves into dir on the same edge that raises step.
            if (pop) dir_d = q0_q;
            case ({push, pop})
                2'b10: begin
                    if (q_cnt_q == 2'd0) q0_d = key_dir;
                    else                 q1_d = key_dir;
                    q_cnt_d = q_cnt_q + 2'd1;
                end
                2'b01: begin
                    q0_d    = q1_q;
                    q_cnt_d = q_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (q_cnt_q == 2'd1) begin
                        q0_d = key_dir;
                    end else begin
                        q0_d = q1_q;
                        q1_d = key_dir;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state uses <= so every flop samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= CNT_W'(BASE_PERIOD);
            step_q   <= 1'b0;
            dir_q    <= DIR_RIGHT;
            q0_q     <= DIR_UP;
            q1_q     <= DIR_UP;
            q_cnt_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            q_cnt_q  <= q_cnt_d;
        end
    end

    assign step    = step_q;
    assign dir     = dir_q;
    assign running = (state_q == ARM) || (state_q == RUN);

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Directed bench for snake_step_scheduler with small periods; expected cycle counts are hand-derived.
module tb_snake_step_scheduler;

`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       init_snake;
    logic       screen_black;
    logic       screen_pause;
    logic [7:0] key_code;
    logic       key_valid;
    logic       grow;
    logic       step;
    logic [1:0] dir;
    logic [3:0] speed_level;
    logic       running;

    int checks = 0;
    int passed = 0;

    snake_step_scheduler #(
        .CNT_W(8), .BASE_PERIOD(10), .PERIOD_DEC(2), .MIN_PERIOD(4),
        .GROWS_PER_LEVEL(2), .MAX_LEVEL(10), .START_DELAY(5)
    ) dut (
        .clk(clk), .rst(rst), .init_snake(init_snake), .screen_black(screen_black),
        .screen_pause(screen_pause), .key_code(key_code), .key_valid(key_valid),
        .grow(grow), .step(step), .dir(dir), .speed_level(speed_level), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        tick();
        grow = 1'b0;
    endtask

    // Cycles until the next step strobe; -1 if none within the budget.
    task automatic wait_step(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < budget);
        if (!step) n = -1;
    endtask

    task automatic count_steps(input int cycles, output int steps);
        steps = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            steps += int'(step);
        end
    endtask

    initial begin
        int n;
        int s1;
        int s2;
        rst = 1'b1; init_snake = 1'b0; screen_black = 1'b0; screen_pause = 1'b0;
        key_code = 8'h00; key_valid = 1'b0; grow = 1'b0;
        tick();
        tick();
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 1);
        check("rst_level", int'(speed_level), 0);
        check("rst_running", int'(running), 0);
        rst = 1'b0;
        tick();
        check("idle_running", int'(running), 0);

        init_snake = 1'b1;
        tick();
        init_snake = 1'b0;
        check("arm_running", int'(running), 1);
        wait_step(40, n);
        check("first_step_delay", n, 15);
        check("first_step_dir", int'(dir), 1);
        tick();
        check("step_one_cycle", int'(step), 0);
        wait_step(40, n);
        check("period_level0", n, 9);

        send_key(8'h6B);
        send_key(8'h74);
        wait_step(40, n);
        check("rev_dup_timing", n, 8);
        check("rev_dup_dropped", int'(dir), 1);

        repeat (6) tick();
        screen_pause = 1'b1;
        count_steps(10, s1);
        send_key(8'h72);
        s1 += int'(step);
        count_steps(9, s2);
        check("pause_no_step", s1 + s2, 0);
        screen_pause = 1'b0;
        wait_step(40, n);
        check("pause_resume", n, 4);
        check("pause_key_ignored", int'(dir), 1);

        send_key(8'h72);
        send_key(8'h6B);
        send_key(8'h75);
        wait_step(40, n);
        check("queue_step1_time", n, 7);
        check("queue_step1_dir", int'(dir), 2);
        wait_step(40, n);
        check("queue_step2_dir", int'(dir), 3);
        wait_step(40, n);
        check("queue_full_drop", int'(dir), 3);

        send_key(8'h75);
        repeat (8) tick();
        send_key(8'h74);
        check("pushpop_step", int'(step), 1);
        check("pushpop_dir", int'(dir), 0);
        wait_step(40, n);
        check("pushpop_next_dir", int'(dir), 1);

        pulse_grow();
        pulse_grow();
        check("level_after_2", int'(speed_level), SPEEDUP ? 1 : 0);
        wait_step(40, n);
        check("level_mid_period", n, 8);
        wait_step(40, n);
        check("period_level1", n, SPEEDUP ? 8 : 10);
        repeat (6) pulse_grow();
        check("level_after_8", int'(speed_level), SPEEDUP ? 4 : 0);
        wait_step(40, n);
        check("period_l1_tail", n, SPEEDUP ? 2 : 4);
        wait_step(40, n);
        check("period_floor", n, SPEEDUP ? 4 : 10);
        repeat (16) pulse_grow();
        check("level_saturate", int'(speed_level), SPEEDUP ? 10 : 0);
        repeat (2) pulse_grow();
        check("level_hold_max", int'(speed_level), SPEEDUP ? 10 : 0);
        wait_step(40, n);
        wait_step(40, n);
        check("period_at_max", n, SPEEDUP ? 4 : 10);

        screen_black = 1'b1;
        tick();
        screen_black = 1'b0;
        check("black_running", int'(running), 0);
        check("black_step", int'(step), 0);
        count_steps(30, s1);
        check("black_no_steps", s1, 0);

        init_snake = 1'b1;
        tick();
        init_snake = 1'b0;
        check("init_level_clear", int'(speed_level), 0);
        check("init_running", int'(running), 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("arm_rst_step", int'(step), 0);
        check("arm_rst_dir", int'(dir), 1);
        check("arm_rst_level", int'(speed_level), 0);
        check("arm_rst_running", int'(running), 0);
        rst = 1'b0;
        count_steps(30, s1);
        check("arm_rst_no_steps", s1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
